// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl
//   Clocked priority interrupt controller. NUM_GROUPS groups of CH_PER_GROUP
//   request lines are captured into a pending register (level or rising-edge),
//   filtered by per-line masks and per-group enables, and the lowest eligible
//   index is presented on a valid/ack handshake, with optional pre-emption by
//   a higher-priority (lower index) request.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   irq_in     request lines, bit g*CH_PER_GROUP+c = channel c of group g
//   mask_in    1 = line masked (combinational, no register)
//   grp_en     1 = group enabled
//   req_ack    consumer accepts the presented request (only while req_valid)
//   req_valid  request presented
//   req_id     flat index of the presented line
//   req_grp    one-hot group of the presented line
//   req_ch     channel within the group
//   pending    pending register
module irq_prio_ctrl #(
  parameter int NUM_GROUPS   = 3,
  parameter int CH_PER_GROUP = 9,
  parameter int EDGE_MODE    = 0,
  parameter int PREEMPT      = 1,
  localparam int N  = NUM_GROUPS * CH_PER_GROUP,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(CH_PER_GROUP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          irq_in,
  input  logic [N-1:0]          mask_in,
  input  logic [NUM_GROUPS-1:0] grp_en,
  input  logic                  req_ack,
  output logic                  req_valid,
  output logic [IW-1:0]         req_id,
  output logic [NUM_GROUPS-1:0] req_grp,
  output logic [CW-1:0]         req_ch,
  output logic [N-1:0]          pending
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                state;
  logic [N-1:0]          irq_q;
  logic [N-1:0]          grp_mask;
  logic [N-1:0]          eligible;
  logic [N-1:0]          ack_clr;
  logic                  accept;
  logic                  win_any;
  logic [IW-1:0]         win_id;
  logic [NUM_GROUPS-1:0] win_grp;
  logic [CW-1:0]         win_ch;

  always_comb begin
    grp_mask = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      grp_mask[g*CH_PER_GROUP +: CH_PER_GROUP] = {CH_PER_GROUP{grp_en[g]}};
    end
  end

  assign eligible = pending & ~mask_in & grp_mask;

  // Lowest set index wins; group/channel are produced alongside the flat
  // index so no divider is needed on the output path.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    win_grp = '0;
    win_ch  = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      for (int unsigned c = 0; c < CH_PER_GROUP; c++) begin
        if (!win_any && eligible[g*CH_PER_GROUP + c]) begin
          win_any    = 1'b1;
          win_id     = IW'(g*CH_PER_GROUP + c);
          win_grp    = '0;
          win_grp[g] = 1'b1;
          win_ch     = CW'(c);
        end
      end
    end
  end

  assign accept  = (state == PRESENT) && req_ack;
  assign ack_clr = accept ? (N'(1) << req_id) : '0;

  // Edge mode: a new rising edge overrides a same-cycle ack clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q <= irq_in;
      if (EDGE_MODE != 0) begin
        pending <= (pending & ~ack_clr) | (irq_in & ~irq_q);
      end else begin
        pending <= irq_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_id    <= '0;
      req_grp   <= '0;
      req_ch    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state     <= PRESENT;
            req_valid <= 1'b1;
            req_id    <= win_id;
            req_grp   <= win_grp;
            req_ch    <= win_ch;
          end
        end
        PRESENT: begin
          if (req_ack || !eligible[req_id]) begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end else if ((PREEMPT != 0) && win_any && (win_id < req_id)) begin
            req_id  <= win_id;
            req_grp <= win_grp;
            req_ch  <= win_ch;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb_irq_prio_ctrl
//   Two controllers side by side: u_lvl (level capture, pre-emption on) and
//   u_edg (edge capture, pre-emption off). Expected outputs are pushed to a
//   scoreboard queue together with the stimulus and checked after each edge.
module tb_irq_prio_ctrl;

  localparam int NG = 3;
  localparam int CH = 9;
  localparam int N  = NG * CH;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]  irq_l, mask_l, pend_l;
  logic [NG-1:0] grp_en_l, grp_l;
  logic          ack_l, valid_l;
  logic [4:0]    id_l;
  logic [3:0]    ch_l;

  logic [N-1:0]  irq_e, mask_e, pend_e;
  logic [NG-1:0] grp_en_e, grp_e;
  logic          ack_e, valid_e;
  logic [4:0]    id_e;
  logic [3:0]    ch_e;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    int          inst;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  irq_prio_ctrl #(.NUM_GROUPS(NG), .CH_PER_GROUP(CH), .EDGE_MODE(0), .PREEMPT(1)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_l), .mask_in(mask_l), .grp_en(grp_en_l),
    .req_ack(ack_l), .req_valid(valid_l), .req_id(id_l), .req_grp(grp_l),
    .req_ch(ch_l), .pending(pend_l)
  );

  irq_prio_ctrl #(.NUM_GROUPS(NG), .CH_PER_GROUP(CH), .EDGE_MODE(1), .PREEMPT(0)) u_edg (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_e), .mask_in(mask_e), .grp_en(grp_en_e),
    .req_ack(ack_e), .req_valid(valid_e), .req_id(id_e), .req_grp(grp_e),
    .req_ch(ch_e), .pending(pend_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 valid, 1 id, 2 grp, 3 ch, 4 pending
  function automatic logic [31:0] observe(input int inst, input int kind);
    logic [31:0] r;
    r = '0;
    case (kind)
      0: r = 32'(inst == 0 ? valid_l : valid_e);
      1: r = 32'(inst == 0 ? id_l    : id_e);
      2: r = 32'(inst == 0 ? grp_l   : grp_e);
      3: r = 32'(inst == 0 ? ch_l    : ch_e);
      default: r = 32'(inst == 0 ? pend_l : pend_e);
    endcase
    return r;
  endfunction

  task automatic push(input string tag, input int inst, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Group/channel are derived from the flat index by the bench model.
  task automatic expect_req(input string tag, input int inst, input bit v, input int id);
    push({tag, ".valid"}, inst, 0, 32'(v));
    if (v) begin
      push({tag, ".id"},  inst, 1, 32'(id));
      push({tag, ".grp"}, inst, 2, 32'(1) << (id / CH));
      push({tag, ".ch"},  inst, 3, 32'(id % CH));
    end
  endtask

  task automatic expect_pend(input string tag, input int inst, input logic [N-1:0] p);
    push({tag, ".pend"}, inst, 4, 32'(p));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.inst, e.kind), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  function automatic logic [N-1:0] b(input int i);
    return N'(1) << i;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    irq_l = '0; mask_l = '0; grp_en_l = '1; ack_l = 1'b0;
    irq_e = '0; mask_e = '0; grp_en_e = '1; ack_e = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      push("rst.valid", i, 0, 32'd0);
      push("rst.id",    i, 1, 32'd0);
      push("rst.grp",   i, 2, 32'd0);
      push("rst.ch",    i, 3, 32'd0);
      push("rst.pend",  i, 4, 32'd0);
    end
    drain();
    #10;
    rst_n = 1'b1;
    expect_req("idle", 0, 0, 0);
    tick();

    // Level mode: 20 and 5 together, 5 wins; ack does not clear level pending.
    irq_l = b(20) | b(5);
    expect_req("lvl_k", 0, 0, 0); expect_pend("lvl_k", 0, b(20) | b(5));
    tick();
    expect_req("lvl_k1", 0, 1, 5); expect_pend("lvl_k1", 0, b(20) | b(5));
    tick();
    ack_l = 1'b1;
    expect_req("lvl_ack", 0, 0, 0);
    tick();
    ack_l = 1'b0;
    expect_req("lvl_re", 0, 1, 5);
    tick();

    // Level drop withdraws 5, then 17 is presented.
    irq_l = b(17);
    expect_req("drop_hold", 0, 1, 5);
    tick();
    expect_req("drop_wd", 0, 0, 0); expect_pend("drop_wd", 0, b(17));
    tick();
    expect_req("drop_next", 0, 1, 17);
    tick();

    // Pre-emption: 2 replaces 17 one cycle after pending[2] sets.
    irq_l = b(17) | b(2);
    expect_req("pre_hold", 0, 1, 17); expect_pend("pre_hold", 0, b(17) | b(2));
    tick();
    expect_req("pre_swap", 0, 1, 2);
    tick();

    // Mask withdrawal, next eligible line one cycle later.
    mask_l = b(2);
    expect_req("mask_wd", 0, 0, 0);
    tick();
    expect_req("mask_next", 0, 1, 17);
    tick();

    ack_l = 1'b1; irq_l = '0; mask_l = '0;
    expect_req("clr_ack", 0, 0, 0);
    tick();
    ack_l = 1'b0;
    expect_req("clr_idle", 0, 0, 0); expect_pend("clr_idle", 0, '0);
    tick();

    // Group 0 disabled: 26 beats 0.
    irq_l = b(0) | b(26); grp_en_l = 3'b110;
    expect_req("gen_k", 0, 0, 0); expect_pend("gen_k", 0, b(0) | b(26));
    tick();
    expect_req("gen_pres", 0, 1, 26);
    tick();
    expect_req("gen_hold", 0, 1, 26);
    tick();

    // Edge mode: one-cycle pulse on 12.
    irq_e = b(12);
    expect_req("edg_k", 1, 0, 0); expect_pend("edg_k", 1, b(12));
    tick();
    irq_e = '0;
    expect_req("edg_pres", 1, 1, 12); expect_pend("edg_pres", 1, b(12));
    tick();
    ack_e = 1'b1;
    expect_req("edg_ack", 1, 0, 0); expect_pend("edg_ack", 1, '0);
    tick();
    expect_req("edg_ack2", 1, 0, 0); expect_pend("edg_ack2", 1, '0);
    tick();
    ack_e = 1'b0;

    // No pre-emption: 17 holds until ack although 2 is pending.
    irq_e = b(17);
    expect_req("np_k", 1, 0, 0); expect_pend("np_k", 1, b(17));
    tick();
    expect_req("np_pres", 1, 1, 17);
    tick();
    irq_e = b(17) | b(2);
    expect_req("np_h1", 1, 1, 17); expect_pend("np_h1", 1, b(17) | b(2));
    tick();
    expect_req("np_h2", 1, 1, 17);
    tick();
    expect_req("np_h3", 1, 1, 17);
    tick();
    ack_e = 1'b1;
    expect_req("np_ack", 1, 0, 0); expect_pend("np_ack", 1, b(2));
    tick();
    ack_e = 1'b0;
    expect_req("np_next", 1, 1, 2);
    tick();

    // Ack of 26 coincides with a new rising edge on 26: set wins.
    ack_e = 1'b1;
    expect_req("sc_ack2", 1, 0, 0); expect_pend("sc_ack2", 1, '0);
    tick();
    ack_e = 1'b0; irq_e = b(26);
    expect_req("sc_k", 1, 0, 0); expect_pend("sc_k", 1, b(26));
    tick();
    irq_e = '0;
    expect_req("sc_pres", 1, 1, 26);
    tick();
    irq_e = b(26); ack_e = 1'b1;
    expect_req("sc_both", 1, 0, 0); expect_pend("sc_both", 1, b(26));
    tick();
    ack_e = 1'b0;
    expect_req("sc_re", 1, 1, 26);
    tick();

    // Asynchronous reset mid-PRESENT.
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      push("arst.valid", i, 0, 32'd0);
      push("arst.id",    i, 1, 32'd0);
      push("arst.pend",  i, 4, 32'd0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
